// File: rtl/sd_pkg.sv
// Shared definitions for the SD stream loader: FSM state encoding and default sizing.
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_INIT = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_DATA = 3'd3,
    ST_FINISH    = 3'd4,
    ST_FAULT     = 3'd5
  } sd_state_e;

  localparam int SD_FIFO_DEPTH  = 8;
  localparam int SD_TIMEOUT     = 4096;
  localparam int SD_ADDR_STRIDE = 4;

endpackage

// File: rtl/sd_word_fifo.sv
// Synchronous word FIFO, pointer + occupancy count, no write-to-read bypass.
module sd_word_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty     = (r_count == '0);
  assign full      = (r_count == FULL_COUNT);
  assign head      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  // A pop on the same edge frees the slot the push lands in, so full+push+pop is legal.
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sd_stream_loader.sv
// Reads a run of 32-bit words from an SD controller, one outstanding read at a time,
// and streams them out through a small FIFO.
module sd_stream_loader
  import sd_pkg::*;
#(
  parameter int FIFO_DEPTH  = SD_FIFO_DEPTH,
  parameter int TIMEOUT     = SD_TIMEOUT,
  parameter int ADDR_STRIDE = SD_ADDR_STRIDE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] word_count,
  input  logic        init_done,
  output logic        read_start,
  output logic [31:0] addr,
  input  logic [31:0] data,
  input  logic        read_done,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output sd_state_e   dbg_state
);

  sd_state_e   r_state;
  sd_state_e   w_next;
  logic [31:0] r_addr;
  logic [15:0] r_remaining;
  logic [31:0] r_tmo;
  logic        r_done;
  logic        r_error;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_issue;
  logic        w_timeout;

  // out_valid/out_ready: a word moves on any cycle both are high; out_data holds while stalled.
  assign w_pop     = out_valid && out_ready;
  assign w_push    = (r_state == ST_WAIT_DATA) && read_done;
  assign w_issue   = (r_state == ST_ISSUE) && !w_full;
  assign w_timeout = (r_state == ST_WAIT_DATA) && !read_done && (r_tmo == 32'(TIMEOUT - 1));

  assign read_start = w_issue;
  assign addr       = r_addr;
  assign out_valid  = !w_empty;
  assign busy       = (r_state == ST_WAIT_INIT) || (r_state == ST_ISSUE) ||
                      (r_state == ST_WAIT_DATA) || (r_state == ST_FINISH);
  assign done       = r_done;
  assign error      = r_error;
  assign dbg_state  = r_state;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (start) w_next = (word_count == 16'd0) ? ST_FINISH : ST_WAIT_INIT;
      ST_WAIT_INIT: if (init_done) w_next = ST_ISSUE;
      ST_ISSUE:     if (!w_full) w_next = ST_WAIT_DATA;
      ST_WAIT_DATA: begin
        if (read_done)      w_next = (r_remaining == 16'd1) ? ST_FINISH : ST_ISSUE;
        else if (w_timeout) w_next = ST_FAULT;
      end
      ST_FINISH:    w_next = ST_IDLE;
      ST_FAULT:     w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_tmo       <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == ST_FINISH);
      if ((r_state == ST_IDLE) && start) begin
        r_addr      <= base_addr;
        r_remaining <= word_count;
        r_error     <= 1'b0;
      end
      if (w_issue) r_tmo <= '0;
      else if ((r_state == ST_WAIT_DATA) && !read_done) r_tmo <= r_tmo + 1'b1;
      // The address advances only after the word lands, so it holds through ISSUE and WAIT_DATA.
      if (w_push) begin
        r_addr      <= r_addr + 32'(ADDR_STRIDE);
        r_remaining <= r_remaining - 1'b1;
      end
      if (w_timeout) r_error <= 1'b1;
    end
  end

  sd_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (data),
    .pop       (w_pop),
    .head      (out_data),
    .full      (w_full),
    .empty     (w_empty)
  );

endmodule

// File: tb/tb_sd_stream_loader.sv
// Directed bench for sd_stream_loader: vector table of transfers plus hand-written corner sequences.
module tb_sd_stream_loader;
  import sd_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic        init_done;
  logic        read_start;
  logic [31:0] addr;
  logic [31:0] data;
  logic        read_done;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        error;
  sd_state_e   dbg_state;

  int checks = 0;
  int errors = 0;

  // Card model controls and logs
  logic        card_en;
  int          card_lat;
  logic [31:0] card_next_data;
  logic        card_rd_done;
  logic [31:0] card_data;
  logic        man_rd_done;
  logic [31:0] man_data;
  logic [31:0] rs_addr_q[$];
  int          rs_count;
  int          done_count;
  logic [31:0] exp_q[$];

  assign read_done = card_rd_done | man_rd_done;
  assign data      = man_rd_done ? man_data : card_data;

  sd_stream_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .init_done  (init_done),
    .read_start (read_start),
    .addr       (addr),
    .data       (data),
    .read_done  (read_done),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected run to complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Card model: answers each read_start after card_lat edges with the next data word.
  initial begin
    card_rd_done = 1'b0;
    card_data    = '0;
    forever begin
      @(negedge clk);
      if (read_start) begin
        rs_addr_q.push_back(addr);
        rs_count++;
        if (card_en) begin
          repeat (card_lat) @(posedge clk);
          #1;
          card_rd_done = 1'b1;
          card_data    = card_next_data;
          card_next_data = card_next_data + 1;
          @(posedge clk);
          #1;
          card_rd_done = 1'b0;
        end
      end
    end
  end

  // Scoreboard on the output stream
  initial begin
    logic [31:0] exp_w;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream_extra: got %h expected no word", out_data);
        end else begin
          exp_w = exp_q.pop_front();
          check("stream_word", out_data, exp_w);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done) done_count++;
    end
  end

  // Driver tasks
  task automatic pulse_start(input logic [31:0] b, input logic [15:0] n);
    @(posedge clk);
    #1;
    base_addr  = b;
    word_count = n;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic wait_rs(input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (read_start) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic clear_logs();
    rs_addr_q.delete();
    rs_count = 0;
  endtask

  typedef struct {
    logic [31:0] base;
    logic [15:0] cnt;
    int          lat;
    logic [31:0] d0;
    int          exp_pulses;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n;
    int d0;
    reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    init_done = 1'b0; out_ready = 1'b0; card_en = 1'b1; card_lat = 1;
    card_next_data = '0; man_rd_done = 1'b0; man_data = '0;
    rs_count = 0; done_count = 0;

    vecs[0] = '{32'h0000_0100, 16'd3, 1, 32'h0000_00A0, 3, 32'h0000_0108};
    vecs[1] = '{32'hFFFF_FFFC, 16'd2, 2, 32'h0000_0050, 2, 32'h0000_0000};
    vecs[2] = '{32'h0000_2000, 16'd1, 3, 32'h1234_0000, 1, 32'h0000_2000};
    vecs[3] = '{32'h0000_7000, 16'd0, 1, 32'h0000_0000, 0, 32'h0000_0000};
    vecs[4] = '{32'h1234_5670, 16'd5, 2, 32'h0BAD_0000, 5, 32'h1234_5680};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_read_start", 32'(read_start), 32'd0);
    check("rst_addr", addr, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Table-driven transfers
    init_done = 1'b1;
    out_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      clear_logs();
      d0 = done_count;
      card_lat = vecs[v].lat;
      card_next_data = vecs[v].d0;
      for (int i = 0; i < int'(vecs[v].cnt); i++) exp_q.push_back(vecs[v].d0 + 32'(i));
      pulse_start(vecs[v].base, vecs[v].cnt);
      wait_done(300, "vec_done_seen");
      repeat (4) @(negedge clk);
      check("vec_pulses", 32'(rs_count), 32'(vecs[v].exp_pulses));
      for (int i = 0; i < rs_addr_q.size(); i++)
        check("vec_addr", rs_addr_q[i], vecs[v].base + 32'(i * 4));
      if (vecs[v].exp_pulses > 0 && rs_addr_q.size() > 0)
        check("vec_last_addr", rs_addr_q[rs_addr_q.size() - 1], vecs[v].exp_last);
      check("vec_done_pulses", 32'(done_count - d0), 32'd1);
      check("vec_error", 32'(error), 32'd0);
      check("vec_drained", 32'(exp_q.size()), 32'd0);
      check("vec_out_valid", 32'(out_valid), 32'd0);
    end

    // Zero-length transfer: busy one cycle, done two cycles after start
    pulse_start(32'h0000_0040, 16'd0);
    @(negedge clk);
    check("zero_busy_c1", 32'(busy), 32'd1);
    check("zero_done_c1", 32'(done), 32'd0);
    @(negedge clk);
    check("zero_busy_c2", 32'(busy), 32'd0);
    check("zero_done_c2", 32'(done), 32'd1);
    @(negedge clk);
    check("zero_done_c3", 32'(done), 32'd0);

    // Minimum latency: read_start two cycles after an accepted start with init_done high
    clear_logs();
    card_lat = 1;
    card_next_data = 32'h0000_00E0;
    exp_q.push_back(32'h0000_00E0);
    pulse_start(32'h0000_0080, 16'd1);
    @(negedge clk);
    check("lat_rs_c1", 32'(read_start), 32'd0);
    @(negedge clk);
    check("lat_rs_c2", 32'(read_start), 32'd1);
    check("lat_addr_c2", addr, 32'h0000_0080);
    wait_done(20, "lat_done_seen");
    repeat (3) @(negedge clk);

    // WAIT_INIT holds until init_done
    clear_logs();
    init_done = 1'b0;
    card_next_data = 32'h0000_00E8;
    exp_q.push_back(32'h0000_00E8);
    pulse_start(32'h0000_0090, 16'd1);
    repeat (6) @(negedge clk);
    check("init_hold_rs", 32'(rs_count), 32'd0);
    check("init_hold_state", 32'(dbg_state), 32'(ST_WAIT_INIT));
    @(posedge clk);
    #1;
    init_done = 1'b1;
    wait_rs(5, "init_rs_seen");
    wait_done(20, "init_done_seen");
    repeat (3) @(negedge clk);
    check("init_drained", 32'(exp_q.size()), 32'd0);

    // Back-pressure: full FIFO stalls issue; a start while busy is ignored
    clear_logs();
    out_ready = 1'b0;
    card_lat = 1;
    card_next_data = 32'h0000_0B00;
    for (int i = 0; i < 12; i++) exp_q.push_back(32'h0000_0B00 + 32'(i));
    pulse_start(32'h0000_0300, 16'd12);
    repeat (100) @(negedge clk);
    check("bp_pulses_stalled", 32'(rs_count), 32'd8);
    check("bp_state", 32'(dbg_state), 32'(ST_ISSUE));
    check("bp_busy", 32'(busy), 32'd1);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    pulse_start(32'hDEAD_0000, 16'd1);
    repeat (4) @(negedge clk);
    check("bp_ignored_start", 32'(rs_count), 32'd8);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_done(300, "bp_done_seen");
    repeat (4) @(negedge clk);
    check("bp_pulses_total", 32'(rs_count), 32'd12);
    for (int i = 0; i < rs_addr_q.size(); i++)
      check("bp_addr", rs_addr_q[i], 32'h0000_0300 + 32'(i * 4));
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Timeout: withheld read_done faults after TIMEOUT cycles in WAIT_DATA
    clear_logs();
    card_en = 1'b0;
    pulse_start(32'h0000_0500, 16'd2);
    wait_rs(10, "tmo_rs_seen");
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!error && n < 5000);
    check("tmo_cycles", 32'(n), 32'd4097);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_state", 32'(dbg_state), 32'(ST_FAULT));
    @(negedge clk);
    check("tmo_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("tmo_error_sticky", 32'(error), 32'd1);
    card_en = 1'b1;
    card_next_data = 32'h0000_00F0;
    exp_q.push_back(32'h0000_00F0);
    pulse_start(32'h0000_0510, 16'd1);
    @(negedge clk);
    check("tmo_error_cleared", 32'(error), 32'd0);
    wait_done(20, "tmo_recover_done");
    repeat (3) @(negedge clk);

    // Reset during WAIT_DATA of word 2; a late read_done is ignored
    clear_logs();
    card_en = 1'b0;
    out_ready = 1'b0;
    pulse_start(32'h0000_0600, 16'd3);
    wait_rs(10, "rst_mid_rs1");
    @(posedge clk);
    #1;
    man_rd_done = 1'b1;
    man_data = 32'h0000_00C0;
    @(posedge clk);
    #1;
    man_rd_done = 1'b0;
    wait_rs(10, "rst_mid_rs2");
    check("rst_mid_addr2", addr, 32'h0000_0604);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_read_start", 32'(read_start), 32'd0);
    check("rst_mid_addr", addr, 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_error", 32'(error), 32'd0);
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk);
    #1;
    reset = 1'b0;
    man_rd_done = 1'b1;
    man_data = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    man_rd_done = 1'b0;
    repeat (2) @(negedge clk);
    check("late_rd_out_valid", 32'(out_valid), 32'd0);
    check("late_rd_busy", 32'(busy), 32'd0);
    check("late_rd_state", 32'(dbg_state), 32'(ST_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_stream_loader.md
SD_STREAM_LOADER -- requirements
Module: sd_stream_loader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, output word buffer depth (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT, default 4096, max clk cycles waiting for read_done per word.
REQ-003 SHALL have parameter ADDR_STRIDE, default 4, byte increment between successive word reads.
REQ-004 SHALL have port clk  input  1  SD clock domain clock.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a transfer.
REQ-007 SHALL have port base_addr  input  32  first card address, sampled on accepted start.
REQ-008 SHALL have port word_count  input  16  number of 32-bit words, sampled on accepted start.
REQ-009 SHALL have port init_done  input  1  SD controller ready for reads.
REQ-010 SHALL have port read_start  output  1  one-cycle read request pulse to SD controller.
REQ-011 SHALL have port addr  output  32  card address for current read.
REQ-012 SHALL have port data  input  32  word returned by SD controller.
REQ-013 SHALL have port read_done  input  1  data valid strobe from SD controller.
REQ-014 SHALL have ports out_data  output  32, out_valid  output  1, out_ready  input  1  stream to consumer.
REQ-015 SHALL have ports busy  output  1, done  output  1 (one-cycle pulse), error  output  1 (sticky until next start).

Function
REQ-016 FSM states SHALL be IDLE, WAIT_INIT, ISSUE, WAIT_DATA, FINISH, FAULT.
REQ-017 IDLE: start SHALL be accepted only in IDLE; accepted start latches base_addr, word_count, clears error, goes to WAIT_INIT.
REQ-018 start outside IDLE SHALL be ignored.
REQ-019 word_count==0 on accepted start SHALL go directly to FINISH; done pulses the following cycle, no read_start issued.
REQ-020 WAIT_INIT: SHALL remain until init_done=1, then ISSUE.
REQ-021 ISSUE: SHALL assert read_start for exactly one cycle only when FIFO occupancy < FIFO_DEPTH, then WAIT_DATA; otherwise stall in ISSUE.
REQ-022 addr SHALL equal base_addr + index*ADDR_STRIDE, modulo 2^32 (wrap silently), stable from ISSUE through WAIT_DATA.
REQ-023 Minimum latency: start accepted with init_done=1 -> read_start asserted 2 cycles later.
REQ-024 WAIT_DATA: read_done=1 SHALL push data into FIFO same edge, increment index, decrement remaining; remaining reaching 0 -> FINISH, else ISSUE.
REQ-025 read_done outside WAIT_DATA SHALL be ignored.
REQ-026 WAIT_DATA: timeout counter SHALL reset on entry; reaching TIMEOUT cycles without read_done -> FAULT.
REQ-027 FAULT: error=1, busy=0, return to IDLE next cycle; FIFO contents retained.
REQ-028 FINISH: done=1 for one cycle, then IDLE; done SHALL NOT wait for FIFO drain.
REQ-029 busy SHALL be 1 in WAIT_INIT, ISSUE, WAIT_DATA, FINISH.
REQ-030 FIFO: out_valid = not empty; pop on out_valid & out_ready; out_data = head word, first-word-first-out.
REQ-031 Simultaneous push and pop SHALL keep occupancy unchanged, including when full or empty-with-push (no bypass: pushed word visible next cycle).
REQ-032 Push SHALL never occur when full (guaranteed by REQ-021, single outstanding read).

Reset
REQ-033 On reset: state IDLE, read_start=0, addr=0, busy=0, done=0, error=0, out_valid=0, FIFO flushed, counters 0.
REQ-034 Reset mid-transfer SHALL abort immediately; a read_done arriving after reset release SHALL be ignored.

Structure
REQ-035 State enum, default FIFO_DEPTH/TIMEOUT/ADDR_STRIDE constants SHALL reside in shared package sd_pkg.
REQ-036 FIFO SHALL be sub-module sd_word_fifo (sync, pointer+count, full/empty flags).
REQ-037 Block SHALL connect to SD controller ports read_start, addr, data, read_done, init_done without glue logic.

Verification
REQ-038 base_addr=0x00000100, word_count=3, card model returns 0xA0,0xA1,0xA2 -> addrs 0x100,0x104,0x108; out stream A0,A1,A2; one done pulse.
REQ-039 word_count=0 -> no read_start, done 2 cycles after start, busy pulses 1 cycle.
REQ-040 FIFO_DEPTH=8, word_count=12, out_ready=0 -> exactly 8 read_start pulses then stall; out_ready=1 -> remaining 4 complete, 12 words in order.
REQ-041 base_addr=0xFFFFFFFC, word_count=2 -> addrs 0xFFFFFFFC then 0x00000000.
REQ-042 Card model withholds read_done -> FAULT after 4096 cycles, error=1, busy=0; next start clears error.
REQ-043 reset asserted during WAIT_DATA of word 2 -> all outputs at reset values next cycle, out_valid=0; late read_done ignored.
